// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the SIPO deserializer and its clock-enable divider.
// Holds the FSM state encoding and the counter-width helper.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned BCNT_W    = $clog2(WIDTH_DEF);

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_deserializer_clk_en_gen.sv
// Free-running divider producing a single-cycle enable every CLK_DIV system clocks.
// The enable is used directly as a shift qualifier; no derived clock is generated.
module clk_en_gen
    import sipo_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DW = cnt_bits(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // With CLK_DIV=1 the counter is pinned at zero, so the enable is always high.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out capture stage: rebuilds MSB-first words on divided shift ticks
// and presents them with a valid/ack handshake, sticky overrun and a delivered-word count.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin,
    input  logic             dout_ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned BW = cnt_bits(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    logic             r_busy;
    // The shift register MSB is never observable, so only WIDTH-1 bits are kept.
    logic [WIDTH-2:0] r_sr;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_tick;
    logic             w_complete;
    logic             w_accept;
    logic [WIDTH-1:0] w_word;

    clk_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_word     = {r_sr, sin};
    assign w_complete = (r_state == SHIFT) && w_tick && (r_bit_cnt == LAST_BIT);
    assign w_accept   = !r_valid || dout_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SHIFT;
                        r_busy    <= 1'b1;
                        r_sr      <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (w_complete) begin
                        // A start in the completion cycle chains straight into the next frame.
                        r_sr      <= '0;
                        r_bit_cnt <= '0;
                        if (!start) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (start) begin
                        r_sr      <= '0;
                        r_bit_cnt <= '0;
                    end else if (w_tick) begin
                        r_sr      <= w_word[WIDTH-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_complete) begin
            if (w_accept) begin
                r_dout      <= w_word;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (dout_ack && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: stimulus pushes expected words, per-instance monitors pop on delivery.
// Instance A uses CLK_DIV=5, instance B uses CLK_DIV=1 for back-to-back frames.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, sin_a, ack_a;
    logic [15:0] dout_a;
    logic        valid_a, busy_a, ovr_a;
    logic [7:0]  fc_a;

    logic        rst_b, start_b, sin_b, ack_b;
    logic [15:0] dout_b;
    logic        valid_b, busy_b, ovr_b;
    logic [7:0]  fc_b;

    sipo_deserializer #(.WIDTH(16), .CLK_DIV(5), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .sin(sin_a), .dout_ack(ack_a),
        .dout(dout_a), .dout_valid(valid_a), .busy(busy_a), .overrun(ovr_a), .frame_cnt(fc_a)
    );

    sipo_deserializer #(.WIDTH(16), .CLK_DIV(1), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .sin(sin_b), .dout_ack(ack_b),
        .dout(dout_b), .dout_valid(valid_b), .busy(busy_b), .overrun(ovr_b), .frame_cnt(fc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    // Independent model of the free-running divide-by-5 enable for instance A.
    int m_div = 0;
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) m_div <= 0;
        else        m_div <= (m_div == 4) ? 0 : m_div + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] prev_a = 8'd0;
    always @(negedge clk) begin
        if (!rst_a) begin
            prev_a = 8'd0;
        end else if (fc_a != prev_a) begin
            prev_a = fc_a;
            if (q_a.size() == 0) chk("a_unexpected_word", {16'd0, dout_a}, 32'hFFFF_FFFF);
            else                 chk("a_word", {16'd0, dout_a}, {16'd0, q_a.pop_front()});
        end
    end

    logic [7:0] prev_b = 8'd0;
    always @(negedge clk) begin
        if (!rst_b) begin
            prev_b = 8'd0;
        end else if (fc_b != prev_b) begin
            prev_b = fc_b;
            if (q_b.size() == 0) chk("b_unexpected_word", {16'd0, dout_b}, 32'hFFFF_FFFF);
            else                 chk("b_word", {16'd0, dout_b}, {16'd0, q_b.pop_front()});
        end
    end

    // All A tasks are entered and left at a negedge.
    task automatic a_start();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic a_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            while (m_div != 4) @(negedge clk);
            sin_a = w[15 - i];
            @(negedge clk);
        end
    endtask

    task automatic a_reset();
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b0; start_a = 1'b0; sin_a = 1'b0; ack_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; sin_b = 1'b0; ack_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_dout",      {16'd0, dout_a}, 32'h0);
        chk("rst_valid",     {31'd0, valid_a}, 32'h0);
        chk("rst_busy",      {31'd0, busy_a},  32'h0);
        chk("rst_overrun",   {31'd0, ovr_a},   32'h0);
        chk("rst_frame_cnt", {24'd0, fc_a},    32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Basic frame and ack
        a_start();
        chk("t2_busy_mid", {31'd0, busy_a}, 32'h1);
        q_a.push_back(16'hA5C3);
        a_bits(16'hA5C3, 16);
        chk("t2_valid", {31'd0, valid_a}, 32'h1);
        chk("t2_dout",  {16'd0, dout_a},  32'hA5C3);
        chk("t2_fc",    {24'd0, fc_a},    32'h1);
        chk("t2_busy",  {31'd0, busy_a},  32'h0);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        chk("t2_valid_after_ack", {31'd0, valid_a}, 32'h0);
        chk("t2_dout_held",       {16'd0, dout_a},  32'hA5C3);

        // Overrun: second word dropped
        a_reset();
        a_start();
        q_a.push_back(16'h1234);
        a_bits(16'h1234, 16);
        a_start();
        a_bits(16'hFFFF, 16);
        chk("t3_dout",    {16'd0, dout_a},  32'h1234);
        chk("t3_overrun", {31'd0, ovr_a},   32'h1);
        chk("t3_fc",      {24'd0, fc_a},    32'h1);
        chk("t3_valid",   {31'd0, valid_a}, 32'h1);

        // Restart mid-frame discards partial bits
        a_reset();
        a_start();
        a_bits(16'hFFFF, 7);
        a_start();
        q_a.push_back(16'h00FF);
        a_bits(16'h00FF, 16);
        chk("t4_dout",    {16'd0, dout_a}, 32'h00FF);
        chk("t4_fc",      {24'd0, fc_a},   32'h1);
        chk("t4_overrun", {31'd0, ovr_a},  32'h0);

        // Reset mid-frame after 9 bits
        a_start();
        a_bits(16'hFFFF, 9);
        chk("t6_busy_mid", {31'd0, busy_a}, 32'h1);
        rst_a = 1'b0;
        #1;
        chk("t6_rst_dout",  {16'd0, dout_a},  32'h0);
        chk("t6_rst_valid", {31'd0, valid_a}, 32'h0);
        chk("t6_rst_busy",  {31'd0, busy_a},  32'h0);
        chk("t6_rst_ovr",   {31'd0, ovr_a},   32'h0);
        chk("t6_rst_fc",    {24'd0, fc_a},    32'h0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        a_start();
        q_a.push_back(16'h8001);
        a_bits(16'h8001, 16);
        chk("t6_dout",  {16'd0, dout_a},  32'h8001);
        chk("t6_valid", {31'd0, valid_a}, 32'h1);
        chk("t6_fc",    {24'd0, fc_a},    32'h1);

        // Back-to-back frames on CLK_DIV=1, start coincides with the final bit
        begin
            logic [15:0] w0, w1, w2;
            w0 = 16'hBEEF;
            w1 = 16'hCAFE;
            w2 = 16'h1357;
            @(negedge clk);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            q_b.push_back(w0);
            for (int i = 0; i < 16; i++) begin
                sin_b = w0[15 - i];
                if (i == 15) start_b = 1'b1;
                @(negedge clk);
            end
            start_b = 1'b0;
            chk("t5_valid0", {31'd0, valid_b}, 32'h1);
            chk("t5_busy0",  {31'd0, busy_b},  32'h1);
            chk("t5_fc0",    {24'd0, fc_b},    32'h1);
            q_b.push_back(w1);
            for (int i = 0; i < 16; i++) begin
                sin_b = w1[15 - i];
                ack_b = (i == 0);
                @(negedge clk);
                if (i == 0) chk("t5_valid_acked", {31'd0, valid_b}, 32'h0);
            end
            ack_b = 1'b0;
            chk("t5_valid1", {31'd0, valid_b}, 32'h1);
            chk("t5_fc1",    {24'd0, fc_b},    32'h2);
            chk("t5_busy1",  {31'd0, busy_b},  32'h0);
            chk("t5_ovr1",   {31'd0, ovr_b},   32'h0);

            // Ack in the completion cycle lets a new word replace an unread one
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            q_b.push_back(w2);
            for (int i = 0; i < 16; i++) begin
                sin_b = w2[15 - i];
                ack_b = (i == 15);
                @(negedge clk);
            end
            ack_b = 1'b0;
            chk("t5_fc2",    {24'd0, fc_b},    32'h3);
            chk("t5_ovr2",   {31'd0, ovr_b},   32'h0);
            chk("t5_valid2", {31'd0, valid_b}, 32'h1);
        end

        repeat (2) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 32'h0);
        chk("b_queue_drained", q_b.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
